// File: rtl/ball_engine.sv
// Pong ball engine: step-timed ball motion, wall/paddle bounces, scoring and serve FSM.
// Optional macro BALL_SPEEDUP_EN adds a per-hit speed increase (1..4 px/step).
module ball_engine #(
  parameter int STEP_DIV   = 500000,
  parameter int HOLD_STEPS = 32
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        SERVE,
  input  logic [7:0]  POS_L,
  input  logic [7:0]  POS_R,
  output logic [10:0] BALL_H,
  output logic [10:0] BALL_V,
  output logic [3:0]  SCORE_L,
  output logic [3:0]  SCORE_R,
  output logic        POINT,
  output logic        GAME_OVER
);
  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [TW-1:0] STEP_MAX  = TW'(STEP_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);
  localparam logic [10:0] CTR_H = 11'd316;
  localparam logic [10:0] CTR_V = 11'd236;

  typedef enum logic [1:0] {IDLE, PLAY, HOLD, GAMEOVER} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [10:0]   ball_h_q, ball_h_d, ball_v_q, ball_v_d;
  logic [3:0]    score_l_q, score_l_d, score_r_q, score_r_d;
  logic          point_q, point_d;
  logic          dir_h_q, dir_h_d;   // 1 = right
  logic          dir_v_q, dir_v_d;   // 1 = down
  logic [10:0]   spd, top_l, top_r;
  logic          step, ovl_l, ovl_r, hit_l, hit_r;

  assign step  = (timer_q == STEP_MAX);
  assign top_l = {2'b00, POS_L, 1'b0};
  assign top_r = {2'b00, POS_R, 1'b0};
  assign ovl_l = (ball_v_q + 11'd8 > top_l) && (ball_v_q < top_l + 11'd64);
  assign ovl_r = (ball_v_q + 11'd8 > top_r) && (ball_v_q < top_r + 11'd64);
  // The h>=24 / h<=608 terms also keep the subtraction below from wrapping.
  assign hit_l = !dir_h_q && (ball_h_q >= 11'd24) && (ball_h_q - spd <= 11'd24) && ovl_l;
  assign hit_r = dir_h_q && (ball_h_q <= 11'd608) && (ball_h_q + spd >= 11'd608) && ovl_r;

`ifdef BALL_SPEEDUP_EN
  logic [2:0] speed_q, speed_d;

  always_comb begin
    speed_d = speed_q;
    if (SERVE && (state_q == IDLE || state_q == GAMEOVER))
      speed_d = 3'd1;
    else if (state_q == PLAY && step && (hit_l || hit_r) && speed_q != 3'd4)
      speed_d = speed_q + 3'd1;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) speed_q <= 3'd1;
    else       speed_q <= speed_d;
  end

  assign spd = {8'd0, speed_q};
`else
  assign spd = 11'd1;
`endif

  always_comb begin
    state_d   = state_q;
    timer_d   = step ? '0 : timer_q + TW'(1);
    hold_d    = hold_q;
    ball_h_d  = ball_h_q;
    ball_v_d  = ball_v_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    point_d   = 1'b0;
    dir_h_d   = dir_h_q;
    dir_v_d   = dir_v_q;
    case (state_q)
      IDLE: begin
        if (SERVE) begin
          state_d = PLAY;
          hold_d  = '0;
        end
      end
      PLAY: begin
        if (step) begin
          if (!dir_v_q) begin
            if (ball_v_q <= spd) begin
              ball_v_d = 11'd0;
              dir_v_d  = 1'b1;
            end else begin
              ball_v_d = ball_v_q - spd;
            end
          end else if (ball_v_q + spd >= 11'd472) begin
            ball_v_d = 11'd472;
            dir_v_d  = 1'b0;
          end else begin
            ball_v_d = ball_v_q + spd;
          end

          if (!dir_h_q) begin
            if (hit_l) begin
              ball_h_d = 11'd24;
              dir_h_d  = 1'b1;
            end else if (ball_h_q <= spd) begin
              ball_h_d  = 11'd0;
              score_r_d = score_r_q + 4'd1;
              point_d   = 1'b1;
              hold_d    = '0;
              state_d   = (score_r_q == 4'd8) ? GAMEOVER : HOLD;
            end else begin
              ball_h_d = ball_h_q - spd;
            end
          end else begin
            if (hit_r) begin
              ball_h_d = 11'd608;
              dir_h_d  = 1'b0;
            end else if (ball_h_q + spd >= 11'd632) begin
              ball_h_d  = 11'd632;
              score_l_d = score_l_q + 4'd1;
              point_d   = 1'b1;
              hold_d    = '0;
              state_d   = (score_l_q == 4'd8) ? GAMEOVER : HOLD;
            end else begin
              ball_h_d = ball_h_q + spd;
            end
          end
        end
      end
      HOLD: begin
        if (step) begin
          if (hold_q == HOLD_LAST) begin
            // Next serve heads back toward the side that just scored.
            dir_h_d  = (ball_h_q == 11'd0);
            ball_h_d = CTR_H;
            ball_v_d = CTR_V;
            hold_d   = '0;
            state_d  = IDLE;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      GAMEOVER: begin
        if (SERVE) begin
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          ball_h_d  = CTR_H;
          ball_v_d  = CTR_V;
          state_d   = PLAY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      hold_q    <= '0;
      ball_h_q  <= CTR_H;
      ball_v_q  <= CTR_V;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
      point_q   <= 1'b0;
      dir_h_q   <= 1'b1;
      dir_v_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      ball_h_q  <= ball_h_d;
      ball_v_q  <= ball_v_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      point_q   <= point_d;
      dir_h_q   <= dir_h_d;
      dir_v_q   <= dir_v_d;
    end
  end

  assign BALL_H    = ball_h_q;
  assign BALL_V    = ball_v_q;
  assign SCORE_L   = score_l_q;
  assign SCORE_R   = score_r_q;
  assign POINT     = point_q;
  assign GAME_OVER = (state_q == GAMEOVER);
endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine with STEP_DIV=4, HOLD_STEPS=2.
// Step k after a serve lands on bench edge count base+4*k (timer restarts at reset).
module tb_ball_engine;
  logic        CLOCK, RESET, SERVE;
  logic [7:0]  POS_L, POS_R;
  logic [10:0] BALL_H, BALL_V;
  logic [3:0]  SCORE_L, SCORE_R;
  logic        POINT, GAME_OVER;

  ball_engine #(.STEP_DIV(4), .HOLD_STEPS(2)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .SERVE(SERVE), .POS_L(POS_L), .POS_R(POS_R),
    .BALL_H(BALL_H), .BALL_V(BALL_V), .SCORE_L(SCORE_L), .SCORE_R(SCORE_R),
    .POINT(POINT), .GAME_OVER(GAME_OVER)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    int step;
    int h;
    int v;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int ecnt = 0;
  int base = 0;
  int hold_h;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    ecnt++;
    #1;
  endtask

  task automatic run_to_step(input int k);
    while (ecnt < base + 4 * k) tick();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    ecnt = 0;
  endtask

  task automatic serve_now();
    SERVE = 1'b1;
    tick();
    SERVE = 1'b0;
  endtask

  task automatic track();
    POS_L = BALL_V[8:1];
    POS_R = (BALL_V < 11'd240) ? 8'd200 : 8'd0;
  endtask

  task automatic check_center(input string name);
    check({name, "_h"}, BALL_H, 316);
    check({name, "_v"}, BALL_V, 236);
  endtask

  vec_t tbl[8];

  initial begin
    int pts;
    int waited;
    bit timed_out;
    RESET = 1'b0; SERVE = 1'b0; POS_L = 8'd0; POS_R = 8'd200;

    // Rally with a right-paddle bounce at the natural trajectory.
    tbl[0] = '{1, 317, 237};
    tbl[1] = '{4, 320, 240};
    tbl[2] = '{235, 551, 471};
    tbl[3] = '{236, 552, 472};
    tbl[4] = '{237, 553, 471};
    tbl[5] = '{291, 607, 417};
    tbl[6] = '{292, 608, 416};
`ifdef BALL_SPEEDUP_EN
    tbl[7] = '{293, 606, 414};
`else
    tbl[7] = '{293, 607, 415};
`endif

    do_reset();
    check_center("rst");
    check("rst_score_l", SCORE_L, 0);
    check("rst_score_r", SCORE_R, 0);
    check("rst_point", POINT, 0);
    check("rst_game_over", GAME_OVER, 0);
    while (ecnt < 8) tick();
    check_center("idle_still");
    serve_now();
    base = 8;
    for (int i = 0; i < 8; i++) begin
      run_to_step(tbl[i].step);
      check($sformatf("rally_h_s%0d", tbl[i].step), BALL_H, tbl[i].h);
      check($sformatf("rally_v_s%0d", tbl[i].step), BALL_V, tbl[i].v);
    end
    check("rally_score_l", SCORE_L, 0);

    // Right miss, hold, re-serve heading left.
    do_reset();
    POS_R = 8'd0;
    serve_now();
    base = 0;
    run_to_step(315);
    check("miss_pre_h", BALL_H, 631);
    check("miss_pre_point", POINT, 0);
    run_to_step(316);
    check("miss_h", BALL_H, 632);
    check("miss_v", BALL_V, 392);
    check("miss_score_l", SCORE_L, 1);
    check("miss_score_r", SCORE_R, 0);
    check("miss_point", POINT, 1);
    serve_now();
    check("miss_point_drop", POINT, 0);
    run_to_step(317);
    check("hold_h", BALL_H, 632);
    check("hold_v", BALL_V, 392);
    run_to_step(318);
    check_center("hold_recenter");
    check("hold_game_over", GAME_OVER, 0);
    serve_now();
    run_to_step(319);
    check("reserve_h", BALL_H, 315);
    check("reserve_v", BALL_V, 235);
    check("reserve_score_l", SCORE_L, 1);

    // Reset with SERVE on a step edge mid-play.
    while (ecnt < 4 * 321 - 1) tick();
    RESET = 1'b1;
    SERVE = 1'b1;
    tick();
    RESET = 1'b0;
    SERVE = 1'b0;
    ecnt = 0;
    check_center("midrst");
    check("midrst_score_l", SCORE_L, 0);
    check("midrst_point", POINT, 0);
    check("midrst_game_over", GAME_OVER, 0);
    while (ecnt < 8) tick();
    check_center("midrst_idle");
    serve_now();
    base = 8;
    run_to_step(1);
    check("midrst_serve_h", BALL_H, 317);
    check("midrst_serve_v", BALL_V, 237);

    // Left paddle always returns, right always misses, until game over.
    pts = 0;
    timed_out = 1'b0;
    while (pts < 9 && !timed_out) begin
      waited = 0;
      while (!POINT && waited < 8000) begin
        track();
        tick();
        waited++;
      end
      if (!POINT) begin
        miscompares++;
        $display("FAIL point_timeout: no point after %0d cycles, expected point %0d", waited, pts + 1);
        timed_out = 1'b1;
      end else begin
        pts++;
        check($sformatf("go_score_l_%0d", pts), SCORE_L, pts);
        check($sformatf("go_score_r_%0d", pts), SCORE_R, 0);
        check($sformatf("go_flag_%0d", pts), GAME_OVER, (pts == 9) ? 1 : 0);
        if (pts < 9) begin
          repeat (9) tick();
          serve_now();
        end
      end
    end
    hold_h = BALL_H;
    repeat (12) tick();
    check("go_frozen_h", BALL_H, 632);
    check("go_frozen_same", BALL_H, hold_h);
    check("go_still_over", GAME_OVER, 1);
    check("go_point_low", POINT, 0);
    serve_now();
    check("go_serve_score_l", SCORE_L, 0);
    check("go_serve_score_r", SCORE_R, 0);
    check("go_serve_flag", GAME_OVER, 0);
    check_center("go_serve");
    repeat (5) tick();
    check("go_serve_moves", (BALL_H != 11'd316) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
